// File: rtl/mips_reg_wb_arbiter.sv
// Writeback arbiter: ALU (A) and load (M) one-entry slots share one registered register-file write port.
// Optional combinational forwarding of pending writes is built when REGWB_BYPASS_EN is defined.
module mips_reg_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              m_valid,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
    output logic              m_ready,
    output logic              reg_write,
    output logic [ADDR_W-1:0] reg_write_addr,
    output logic [DATA_W-1:0] reg_write_data,
    output logic              busy,
    input  logic [ADDR_W-1:0] byp_addr1,
    input  logic [ADDR_W-1:0] byp_addr2,
    output logic              byp_hit1,
    output logic              byp_hit2,
    output logic [DATA_W-1:0] byp_data1,
    output logic [DATA_W-1:0] byp_data2
);

    logic              a_full_q, a_full_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;
    logic              m_full_q, m_full_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              m_older_q, m_older_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    logic grant_a, grant_m;
    logic a_cap, m_cap;

    // Same nonzero destination in both slots must retire oldest-first; otherwise round-robin.
    always_comb begin
        grant_a = 1'b0;
        grant_m = 1'b0;
        if (a_full_q && m_full_q) begin
            if ((a_addr_q == m_addr_q) && (a_addr_q != '0)) begin
                grant_m = m_older_q;
                grant_a = !m_older_q;
            end else begin
                grant_m = rr_ptr_q;
                grant_a = !rr_ptr_q;
            end
        end else begin
            grant_a = a_full_q;
            grant_m = m_full_q;
        end
    end

    assign a_ready = !rst && (!a_full_q || grant_a);
    assign m_ready = !rst && (!m_full_q || grant_m);
    assign a_cap   = a_valid && a_ready;
    assign m_cap   = m_valid && m_ready;

    always_comb begin
        a_full_d  = a_full_q && !grant_a;
        a_addr_d  = a_addr_q;
        a_data_d  = a_data_q;
        m_full_d  = m_full_q && !grant_m;
        m_addr_d  = m_addr_q;
        m_data_d  = m_data_q;
        rr_ptr_d  = (a_full_q && m_full_q) ? !rr_ptr_q : rr_ptr_q;
        m_older_d = m_older_q;
        we_d      = 1'b0;
        wa_d      = wa_q;
        wd_d      = wd_q;

        if (a_cap) begin
            a_full_d = 1'b1;
            a_addr_d = a_addr;
            a_data_d = a_data;
        end
        if (m_cap) begin
            m_full_d = 1'b1;
            m_addr_d = m_addr;
            m_data_d = m_data;
        end

        // A fresh A entry is younger than a surviving M entry, and simultaneous captures rank M older.
        if (a_cap) begin
            m_older_d = 1'b1;
        end else if (m_cap) begin
            m_older_d = 1'b0;
        end

        if (grant_a && (a_addr_q != '0)) begin
            we_d = 1'b1;
            wa_d = a_addr_q;
            wd_d = a_data_q;
        end else if (grant_m && (m_addr_q != '0)) begin
            we_d = 1'b1;
            wa_d = m_addr_q;
            wd_d = m_data_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            a_full_q  <= 1'b0;
            a_addr_q  <= '0;
            a_data_q  <= '0;
            m_full_q  <= 1'b0;
            m_addr_q  <= '0;
            m_data_q  <= '0;
            rr_ptr_q  <= 1'b0;
            m_older_q <= 1'b0;
            we_q      <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
        end else begin
            a_full_q  <= a_full_d;
            a_addr_q  <= a_addr_d;
            a_data_q  <= a_data_d;
            m_full_q  <= m_full_d;
            m_addr_q  <= m_addr_d;
            m_data_q  <= m_data_d;
            rr_ptr_q  <= rr_ptr_d;
            m_older_q <= m_older_d;
            we_q      <= we_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
        end
    end

    assign reg_write      = we_q;
    assign reg_write_addr = wa_q;
    assign reg_write_data = wd_q;
    assign busy           = a_full_q | m_full_q | we_q;

`ifdef REGWB_BYPASS_EN
    logic [ADDR_W-1:0] byp_rd   [2];
    logic              byp_hit  [2];
    logic [DATA_W-1:0] byp_data [2];

    assign byp_rd[0] = byp_addr1;
    assign byp_rd[1] = byp_addr2;

    // Later matches override earlier ones: output register, then older slot, then younger slot.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            byp_hit[i]  = 1'b0;
            byp_data[i] = '0;
            if (byp_rd[i] != '0) begin
                if (we_q && (wa_q == byp_rd[i])) begin
                    byp_hit[i]  = 1'b1;
                    byp_data[i] = wd_q;
                end
                if (m_older_q) begin
                    if (m_full_q && (m_addr_q == byp_rd[i])) begin
                        byp_hit[i]  = 1'b1;
                        byp_data[i] = m_data_q;
                    end
                    if (a_full_q && (a_addr_q == byp_rd[i])) begin
                        byp_hit[i]  = 1'b1;
                        byp_data[i] = a_data_q;
                    end
                end else begin
                    if (a_full_q && (a_addr_q == byp_rd[i])) begin
                        byp_hit[i]  = 1'b1;
                        byp_data[i] = a_data_q;
                    end
                    if (m_full_q && (m_addr_q == byp_rd[i])) begin
                        byp_hit[i]  = 1'b1;
                        byp_data[i] = m_data_q;
                    end
                end
            end
        end
    end

    assign byp_hit1  = byp_hit[0];
    assign byp_hit2  = byp_hit[1];
    assign byp_data1 = byp_data[0];
    assign byp_data2 = byp_data[1];
`else
    logic unused_byp;
    assign unused_byp = ^{byp_addr1, byp_addr2};
    assign byp_hit1   = 1'b0;
    assign byp_hit2   = 1'b0;
    assign byp_data1  = '0;
    assign byp_data2  = '0;
`endif

endmodule

// File: tb/tb_mips_reg_wb_arbiter.sv
// Self-checking bench for mips_reg_wb_arbiter: directed table, hand sequences and randomized traffic
// against a sequence-number based reference model. Bypass expectations follow REGWB_BYPASS_EN.
module tb_mips_reg_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              CLK = 1'b0;
    logic              rst;
    logic              a_valid, m_valid;
    logic [ADDR_W-1:0] a_addr, m_addr;
    logic [DATA_W-1:0] a_data, m_data;
    logic              a_ready, m_ready;
    logic              reg_write;
    logic [ADDR_W-1:0] reg_write_addr;
    logic [DATA_W-1:0] reg_write_data;
    logic              busy;
    logic [ADDR_W-1:0] byp_addr1, byp_addr2;
    logic              byp_hit1, byp_hit2;
    logic [DATA_W-1:0] byp_data1, byp_data2;

    always #5 CLK = ~CLK;

    mips_reg_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
        .reg_write(reg_write), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
        .busy(busy),
        .byp_addr1(byp_addr1), .byp_addr2(byp_addr2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2)
    );

    // Reference model: each held entry carries a capture sequence number; smaller means older.
    typedef struct {
        logic              v;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                seq;
    } slot_t;

    slot_t             mA, mM;
    logic              mTieA;
    logic              mWe;
    logic [ADDR_W-1:0] mWAddr;
    logic [DATA_W-1:0] mWData;
    int                seqCnt;

    int checks = 0;
    int failures = 0;

    logic              obsAR, obsMR, obsWe, obsBusy, obsHit1, obsHit2;
    logic [ADDR_W-1:0] obsWA;
    logic [DATA_W-1:0] obsWD, obsBD1, obsBD2;
    logic [ADDR_W-1:0] writeAddrLog[$];
    logic [DATA_W-1:0] writeDataLog[$];

    typedef struct {
        logic              av;
        logic [ADDR_W-1:0] aa;
        logic [DATA_W-1:0] ad;
        logic              expAR;
        logic              expMR;
        logic              expWe;
        logic [ADDR_W-1:0] expWA;
        logic [DATA_W-1:0] expWD;
        logic              expBusy;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int modelGrant();
        if (mA.v && mM.v) begin
            if ((mA.addr == mM.addr) && (mA.addr != '0))
                return (mA.seq < mM.seq) ? 1 : 2;
            return mTieA ? 1 : 2;
        end
        if (mA.v) return 1;
        if (mM.v) return 2;
        return 0;
    endfunction

    function automatic logic [DATA_W:0] modelByp(input logic [ADDR_W-1:0] ra);
        int                bestSeq;
        logic              hit;
        logic [DATA_W-1:0] d;
        bestSeq = -1;
        hit     = 1'b0;
        d       = '0;
        if (ra == '0) return '0;
        if (mWe && (mWAddr == ra)) begin
            hit = 1'b1;
            d   = mWData;
        end
        if (mA.v && (mA.addr == ra) && (mA.seq > bestSeq)) begin
            hit     = 1'b1;
            d       = mA.data;
            bestSeq = mA.seq;
        end
        if (mM.v && (mM.addr == ra) && (mM.seq > bestSeq)) begin
            hit = 1'b1;
            d   = mM.data;
        end
        return {hit, d};
    endfunction

    task automatic checkAll();
        int                g;
        logic              expAR, expMR;
        logic [DATA_W:0]   b1, b2;
        g     = modelGrant();
        expAR = !rst && (!mA.v || (g == 1));
        expMR = !rst && (!mM.v || (g == 2));
`ifdef REGWB_BYPASS_EN
        b1 = modelByp(byp_addr1);
        b2 = modelByp(byp_addr2);
`else
        b1 = '0;
        b2 = '0;
`endif
        obsAR   = a_ready;
        obsMR   = m_ready;
        obsWe   = reg_write;
        obsWA   = reg_write_addr;
        obsWD   = reg_write_data;
        obsBusy = busy;
        obsHit1 = byp_hit1;
        obsHit2 = byp_hit2;
        obsBD1  = byp_data1;
        obsBD2  = byp_data2;
        if (obsWe === 1'b1) begin
            writeAddrLog.push_back(obsWA);
            writeDataLog.push_back(obsWD);
        end
        checkOutput("a_ready", obsAR, expAR);
        checkOutput("m_ready", obsMR, expMR);
        checkOutput("reg_write", obsWe, mWe);
        if (mWe) begin
            checkOutput("reg_write_addr", obsWA, mWAddr);
            checkOutput("reg_write_data", obsWD, mWData);
        end
        checkOutput("busy", obsBusy, mA.v | mM.v | mWe);
        checkOutput("byp_hit1", obsHit1, b1[DATA_W]);
        checkOutput("byp_data1", obsBD1, b1[DATA_W-1:0]);
        checkOutput("byp_hit2", obsHit2, b2[DATA_W]);
        checkOutput("byp_data2", obsBD2, b2[DATA_W-1:0]);
    endtask

    task automatic modelEdge();
        int   g;
        logic ra, rm;
        g = modelGrant();
        if (rst) begin
            mA.v   = 1'b0;
            mM.v   = 1'b0;
            mTieA  = 1'b1;
            mWe    = 1'b0;
            mWAddr = '0;
            mWData = '0;
            return;
        end
        ra = !mA.v || (g == 1);
        rm = !mM.v || (g == 2);
        if (mA.v && mM.v) mTieA = !mTieA;
        mWe = 1'b0;
        if (g == 1) begin
            if (mA.addr != '0) begin
                mWe    = 1'b1;
                mWAddr = mA.addr;
                mWData = mA.data;
            end
            mA.v = 1'b0;
        end else if (g == 2) begin
            if (mM.addr != '0) begin
                mWe    = 1'b1;
                mWAddr = mM.addr;
                mWData = mM.data;
            end
            mM.v = 1'b0;
        end
        if (m_valid && rm) begin
            mM = '{1'b1, m_addr, m_data, seqCnt};
            seqCnt++;
        end
        if (a_valid && ra) begin
            mA = '{1'b1, a_addr, a_data, seqCnt};
            seqCnt++;
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                                 input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                                 input logic r);
        a_valid = av;
        a_addr  = aa;
        a_data  = ad;
        m_valid = mv;
        m_addr  = ma;
        m_data  = md;
        rst     = r;
        @(negedge CLK);
        checkAll();
        @(posedge CLK);
        modelEdge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    logic [ADDR_W-1:0] aq[$];
    logic [ADDR_W-1:0] mq[$];
    logic [1:0]        readyLog[$];
    logic [ADDR_W-1:0] expOrder[6];
    logic              av, mv;
    int                cyc;

    initial begin
        mA       = '{1'b0, '0, '0, 0};
        mM       = '{1'b0, '0, '0, 0};
        mTieA    = 1'b1;
        mWe      = 1'b0;
        mWAddr   = '0;
        mWData   = '0;
        seqCnt   = 0;
        a_valid  = 1'b0; a_addr = '0; a_data = '0;
        m_valid  = 1'b0; m_addr = '0; m_data = '0;
        byp_addr1 = '0;
        byp_addr2 = '0;
        rst      = 1'b1;
        repeat (2) begin
            @(posedge CLK);
            modelEdge();
        end
        #1;

        // Reset state
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1);
        checkOutput("reset_a_ready", obsAR, 1'b0);
        checkOutput("reset_m_ready", obsMR, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("reset_reg_write", obsWe, 1'b0);
        checkOutput("reset_addr", obsWA, '0);
        checkOutput("reset_data", obsWD, '0);
        checkOutput("reset_busy", obsBusy, 1'b0);

        // Single A write then a write to the zero register
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1};
        vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
        vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
        vecs[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1};
        vecs[6] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k].av, vecs[k].aa, vecs[k].ad, 1'b0, '0, '0, 1'b0);
            checkOutput($sformatf("vec%0d_a_ready", k), obsAR, vecs[k].expAR);
            checkOutput($sformatf("vec%0d_m_ready", k), obsMR, vecs[k].expMR);
            checkOutput($sformatf("vec%0d_reg_write", k), obsWe, vecs[k].expWe);
            checkOutput($sformatf("vec%0d_busy", k), obsBusy, vecs[k].expBusy);
            if (vecs[k].expWe) begin
                checkOutput($sformatf("vec%0d_addr", k), obsWA, vecs[k].expWA);
                checkOutput($sformatf("vec%0d_data", k), obsWD, vecs[k].expWD);
            end
        end

        // Both requesters streaming distinct destinations
        writeAddrLog.delete();
        writeDataLog.delete();
        aq = '{5'd1, 5'd2, 5'd3};
        mq = '{5'd9, 5'd10, 5'd11};
        expOrder = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
        cyc = 0;
        while (((aq.size() > 0) || (mq.size() > 0)) && (cyc < 30)) begin
            av = aq.size() > 0;
            mv = mq.size() > 0;
            applyStimulus(av, av ? aq[0] : '0, av ? (32'h100 + 32'(aq[0])) : '0,
                          mv, mv ? mq[0] : '0, mv ? (32'h200 + 32'(mq[0])) : '0, 1'b0);
            readyLog.push_back({obsAR, obsMR});
            if (av && obsAR) void'(aq.pop_front());
            if (mv && obsMR) void'(mq.pop_front());
            cyc++;
        end
        checkOutput("stream_timeout", cyc < 30, 1'b1);
        idle(4);
        checkOutput("stream_count", writeAddrLog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < writeAddrLog.size())
                checkOutput($sformatf("stream_order%0d", i), writeAddrLog[i], expOrder[i]);
        end
        if (readyLog.size() > 2) begin
            checkOutput("stream_ready_c1", readyLog[1], 2'b10);
            checkOutput("stream_ready_c2", readyLog[2], 2'b01);
        end

        // Reset with both slots full and reg_write high
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0);
        applyStimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        checkOutput("midrst_we_before", obsWe, 1'b1);
        checkOutput("midrst_a_ready", obsAR, 1'b0);
        checkOutput("midrst_m_ready", obsMR, 1'b0);
        applyStimulus(1'b1, 5'd3, 32'hC0FFEE, 1'b0, '0, '0, 1'b0);
        checkOutput("midrst_we_after", obsWe, 1'b0);
        checkOutput("midrst_busy_after", obsBusy, 1'b0);
        checkOutput("midrst_addr_after", obsWA, '0);
        checkOutput("midrst_accept", obsAR, 1'b1);
        idle(1);
        checkOutput("midrst_we_t1", obsWe, 1'b0);
        idle(1);
        checkOutput("midrst_we_t2", obsWe, 1'b1);
        checkOutput("midrst_addr_t2", obsWA, 5'd3);
        checkOutput("midrst_data_t2", obsWD, 32'hC0FFEE);
        idle(2);

        // Same destination in both slots retires oldest-first, overriding the round-robin pointer
        writeAddrLog.delete();
        writeDataLog.delete();
        applyStimulus(1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 32'h33, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'h11, 1'b0);
        checkOutput("waw_m_accept", obsMR, 1'b1);
        idle(5);
        checkOutput("waw_count", writeDataLog.size(), 3);
        if (writeDataLog.size() == 3) begin
            checkOutput("waw_first", writeDataLog[0], 32'h33);
            checkOutput("waw_second", writeDataLog[1], 32'h22);
            checkOutput("waw_third", writeDataLog[2], 32'h11);
        end

        // Pending slot value shadows the output register for the same register
        byp_addr1 = 5'd4;
        byp_addr2 = 5'd0;
        applyStimulus(1'b1, 5'd4, 32'hB, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b1, 5'd4, 32'hA, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("byp_out_we", obsWe, 1'b1);
        checkOutput("byp_out_data", obsWD, 32'hB);
`ifdef REGWB_BYPASS_EN
        checkOutput("byp_hit1_slot", obsHit1, 1'b1);
        checkOutput("byp_data1_slot", obsBD1, 32'hA);
`else
        checkOutput("byp_hit1_off", obsHit1, 1'b0);
        checkOutput("byp_data1_off", obsBD1, '0);
`endif
        checkOutput("byp_hit2_zero", obsHit2, 1'b0);
        idle(2);

        // Randomized traffic with narrow address range to provoke WAW, r0 and bypass overlaps
        for (int i = 0; i < 500; i++) begin
            byp_addr1 = ADDR_W'($urandom_range(0, 7));
            byp_addr2 = ADDR_W'($urandom_range(0, 7));
            applyStimulus($urandom_range(0, 9) < 6, ADDR_W'($urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 9) < 6, ADDR_W'($urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 59) == 0);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
